// File: rtl/mem_bus_pkg.sv
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and constants for the memory bus master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

  localparam int c_default_addr_w  = 16;
  localparam int c_default_data_w  = 16;
  localparam int c_wait_cycles_max = 15;
  localparam int c_cnt_w           = $clog2(c_wait_cycles_max + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_wait_counter.sv
// ============================================================================
// Module      : mem_wait_counter
// Description : Loadable down-counter with zero flag timing the memory access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_counter
  import mem_bus_pkg::*;
#(
  parameter int CNT_W = c_cnt_w
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;

  // Saturates at zero so a stray decrement can never wrap into a long wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mem_bus_master.sv
// ============================================================================
// Module      : mem_bus_master
// Description : Single-outstanding request/response master for a strobed
//               memory with a shared bidirectional data bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = c_default_addr_w,
  parameter int DATA_W      = c_default_data_w,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              enable,
  output logic              load,
  output logic              output_en,
  inout  wire  [DATA_W-1:0] data
);

  localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(WAIT_CYCLES - 1);

  bus_state_e        r_state;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_write;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_enable;
  logic              r_load;
  logic              r_output_en;
  logic              r_drive;

  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_zero;

  // Counter is loaded on the SETUP->WAIT edge so it holds WAIT_CYCLES-1 on entry.
  assign w_cnt_load = (r_state == SETUP);
  assign w_cnt_dec  = (r_state == WAIT);

  mem_wait_counter #(
    .CNT_W (c_cnt_w)
  ) u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (w_cnt_load),
    .load_value (c_wait_load),
    .dec        (w_cnt_dec),
    .zero       (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_address   <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_write     <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_enable    <= 1'b0;
      r_load      <= 1'b0;
      r_output_en <= 1'b0;
      r_drive     <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_state     <= SETUP;
            r_address   <= req_addr;
            r_wdata     <= req_wdata;
            r_write     <= req_write;
            r_req_ready <= 1'b0;
            r_enable    <= 1'b1;
            r_load      <= req_write;
            r_output_en <= !req_write;
            r_drive     <= req_write;
          end
        end
        SETUP: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_cnt_zero) begin
            r_state     <= DONE;
            r_enable    <= 1'b0;
            r_load      <= 1'b0;
            r_output_en <= 1'b0;
            r_drive     <= 1'b0;
            r_rsp_valid <= 1'b1;
            if (!r_write) begin
              r_rsp_rdata <= data;
            end
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Write data and the read drive enable come from exclusive registers, so the
  // bus is never driven while the memory is asked to drive it.
  assign data      = r_drive ? r_wdata : {DATA_W{1'bz}};
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign address   = r_address;
  assign enable    = r_enable;
  assign load      = r_load;
  assign output_en = r_output_en;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_master.sv
// ============================================================================
// Module      : tb_mem_bus_master
// Description : Scoreboard bench for mem_bus_master with WAIT_CYCLES 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_bus_master;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          done_cyc;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  logic preload;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [1:0]       req_valid;
  logic [1:0]       req_write;
  logic [1:0][15:0] req_addr;
  logic [1:0][15:0] req_wdata;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [1:0][15:0] rsp_rdata;
  logic [1:0][15:0] address;
  logic [1:0]       enable;
  logic [1:0]       load;
  logic [1:0]       output_en;

  txn_t sb[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int wc(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_dut
    localparam int W = (i == 0) ? 1 : 3;
    wire  [15:0] bus;
    logic [15:0] mem [0:255];
    int          strobe_cnt = 0;
    txn_t        t;

    mem_bus_master #(
      .ADDR_W      (16),
      .DATA_W      (16),
      .WAIT_CYCLES (W)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[i]),
      .req_ready (req_ready[i]),
      .req_write (req_write[i]),
      .req_addr  (req_addr[i]),
      .req_wdata (req_wdata[i]),
      .rsp_valid (rsp_valid[i]),
      .rsp_rdata (rsp_rdata[i]),
      .address   (address[i]),
      .enable    (enable[i]),
      .load      (load[i]),
      .output_en (output_en[i]),
      .data      (bus)
    );

    // Memory model: drives the bus only when selected for a read.
    assign bus = (enable[i] && output_en[i]) ? mem[address[i][7:0]] : 16'hzzzz;

    always @(posedge clk) begin
      if (preload) begin
        for (int k = 0; k < 256; k++) mem[k] <= 16'h0000;
        if (i == 1) mem[8'h20] <= 16'h1234;
      end else if (enable[i] && load[i]) begin
        mem[address[i][7:0]] <= bus;
      end
    end

    always @(negedge clk) begin
      if (reset) begin
        strobe_cnt = 0;
      end else begin
        if (enable[i]) begin
          strobe_cnt++;
          if (sb[i].size() == 0) begin
            check($sformatf("dut%0d strobe without txn", i), 32'd1, 32'd0);
          end else begin
            check($sformatf("dut%0d address", i), {16'h0, address[i]}, {16'h0, sb[i][0].addr});
            check($sformatf("dut%0d load", i), {31'h0, load[i]}, {31'h0, sb[i][0].write});
            check($sformatf("dut%0d output_en", i), {31'h0, output_en[i]}, {31'h0, !sb[i][0].write});
            check($sformatf("dut%0d bus data", i), {16'h0, bus},
                  {16'h0, sb[i][0].write ? sb[i][0].wdata : sb[i][0].rdata});
          end
        end
        if (rsp_valid[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("dut%0d unexpected rsp_valid", i), 32'd1, 32'd0);
          end else begin
            t = sb[i].pop_front();
            check($sformatf("dut%0d rsp cycle", i), cyc, t.done_cyc);
            check($sformatf("dut%0d strobe cycles", i), strobe_cnt, W + 1);
            check($sformatf("dut%0d rsp_rdata", i), {16'h0, rsp_rdata[i]}, {16'h0, t.rdata});
            check($sformatf("dut%0d address in DONE", i), {16'h0, address[i]}, {16'h0, t.addr});
            check($sformatf("dut%0d strobes in DONE", i), {29'h0, enable[i], load[i], output_en[i]}, 32'd0);
          end
          strobe_cnt = 0;
        end
      end
    end
  end

  // rd is the read data for reads, or the rsp_rdata value expected to be held for writes.
  task automatic issue(input int d, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] rd, input bit hold, output int acc);
    txn_t t;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    acc = -1;
    for (int k = 0; k < 40 && acc < 0; k++) begin
      if (req_ready[d]) begin
        @(posedge clk);
        #1;
        acc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (acc < 0) begin
      check($sformatf("dut%0d accept timeout", d), 32'd0, 32'd1);
    end else begin
      t.write    = wr;
      t.addr     = a;
      t.wdata    = wd;
      t.rdata    = rd;
      t.done_cyc = acc + wc(d) + 1;
      sb[d].push_back(t);
    end
    if (!hold) req_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = rsp_valid[d];
    end
    if (!seen) check($sformatf("dut%0d rsp timeout", d), 32'd0, 32'd1);
  endtask

  task automatic check_reset_state(input int d);
    check($sformatf("dut%0d reset req_ready", d), {31'h0, req_ready[d]}, 32'd1);
    check($sformatf("dut%0d reset rsp_valid", d), {31'h0, rsp_valid[d]}, 32'd0);
    check($sformatf("dut%0d reset rsp_rdata", d), {16'h0, rsp_rdata[d]}, 32'd0);
    check($sformatf("dut%0d reset address", d), {16'h0, address[d]}, 32'd0);
    check($sformatf("dut%0d reset strobes", d), {29'h0, enable[d], load[d], output_en[d]}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    reset     = 1'b1;
    preload   = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    reset = 1'b0;

    // Write then read back, WAIT_CYCLES=1.
    issue(0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, a1);
    issue(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, a1);

    // Read with WAIT_CYCLES=3 from preloaded location.
    issue(1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0, a1);

    // Back-to-back with req_valid held; request fields change during SETUP.
    issue(0, 1'b1, 16'h0001, 16'h7E57, 16'hBEEF, 1'b1, a1);
    issue(0, 1'b0, 16'h0001, 16'h0000, 16'h7E57, 1'b0, a2);
    check("b2b accept spacing", a2, a1 + wc(0) + 3);

    // Garbage on req_* while busy must not disturb the latched transaction.
    issue(0, 1'b1, 16'h0040, 16'h5A5A, 16'h7E57, 1'b0, a1);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 16'hFFFF;
    req_wdata[0] = 16'h0000;
    wait_rsp(0);
    req_valid[0] = 1'b0;
    issue(0, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 1'b0, a1);

    // Reset during WAIT of a write aborts it immediately.
    issue(0, 1'b1, 16'h0030, 16'hCAFE, 16'h5A5A, 1'b0, a1);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    sb[0].delete();
    check_reset_state(0);
    @(negedge clk);
    @(negedge clk);
    check("rsp_valid held in reset", {31'h0, rsp_valid[0]}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("req_ready after reset release", {31'h0, req_ready[0]}, 32'd1);
    issue(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, a1);

    for (int k = 0; k < 60 && (sb[0].size() != 0 || sb[1].size() != 0); k++) @(negedge clk);
    check("dut0 scoreboard drained", sb[0].size(), 32'd0);
    check("dut1 scoreboard drained", sb[1].size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
